// File: rtl/decode_scan_if.sv
// Handshake bundle for decode_scan: control inputs and registered strobe outputs.
interface decode_scan_if #(
  parameter int SEL_W = 2
);
  localparam int OUT_W = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             load;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, sel, load,
    input  out, idx, wrap
  );

  modport slave (
    input  en, mode, sel, load,
    output out, idx, wrap
  );
endinterface

// File: rtl/decode_scan.sv
// Registered one-hot decoder with a DIRECT mode and a dwell-timed
// auto-scan mode; output is glitch-free because every bit is a flop.
module decode_scan #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        reset,
  decode_scan_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam logic [15:0] LAST = 16'(DWELL - 1);
  localparam logic [SEL_W-1:0] TOP = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

  typedef enum logic [1:0] {
    S_OFF,
    S_DIRECT,
    S_SCAN
  } state_t;

  state_t           r_state, w_state;
  logic [OUT_W-1:0] r_out, w_out;
  logic [SEL_W-1:0] r_idx, w_idx;
  logic             r_wrap, w_wrap;
  logic [15:0]      r_cnt, w_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_OFF;
      r_out   <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_out   <= w_out;
      r_idx   <= w_idx;
      r_wrap  <= w_wrap;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_out   = '0;
    w_idx   = r_idx;
    w_wrap  = 1'b0;
    w_cnt   = r_cnt;
    unique case (1'b1)
      !bus.en: begin
        w_state = S_OFF;
      end
      bus.en && !bus.mode: begin
        w_state = S_DIRECT;
        w_idx   = bus.sel;
        w_cnt   = '0;
        w_out   = ONE << w_idx;
      end
      bus.en && bus.mode: begin
        w_state = S_SCAN;
        // Entry and load both restart the dwell; load wins over a step.
        if (r_state != S_SCAN || bus.load) begin
          w_idx = bus.load ? bus.sel : r_idx;
          w_cnt = '0;
        end else if (r_cnt == LAST) begin
          w_cnt  = '0;
          w_idx  = r_idx + 1'b1;
          w_wrap = (r_idx == TOP);
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
        w_out = ONE << w_idx;
      end
      default: begin
        w_state = S_OFF;
      end
    endcase
  end

  assign bus.out  = r_out;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;
endmodule
